// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: hazard unit for the 5-stage F/D/E/M/W core.
// Selects E-stage operand forwarding and raises load-use stalls. It also holds
// multi-cycle E ops with a countdown, applies branch/jump redirects, and keeps
// saturating stall/flush event counters.
module hazard_ctrl_mc #(
  parameter int REG_W  = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic [REG_W-1:0] dst_e,
  input  logic [REG_W-1:0] dst_m,
  input  logic [REG_W-1:0] dst_w,
  input  logic             reg_write_e,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             mem_to_reg_e,
  input  logic             mem_to_reg_m,
  input  logic             mc_op_e,
  input  logic             redirect_e,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  // Countdown width; a single-cycle latency still needs a 1-bit (always zero) counter.
  localparam int               CW       = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam bit               MC_EN    = (MC_LAT > 1);
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(MC_LAT - 1);
  localparam logic [CNT_W-1:0] PERF_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PERF_ONE = CNT_W'(1);
  localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu_raw_s, mc_raw_s;
  logic             lu_s, mc_stall_s, redir_s;

  // Operand source: the M ALU result wins over W; a load still in M has no data yet.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] dm,
    input logic             wm,
    input logic             lm,
    input logic [REG_W-1:0] dw,
    input logic             ww
  );
    logic [1:0] sel;
    if (wm && !lm && (dm != REG_ZERO) && (dm == src)) begin
      sel = 2'b10;
    end else if (ww && (dw != REG_ZERO) && (dw == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Forwarding selects for both E operands, independent of each other.
  always_comb begin
    fwd_a_e = fwd_sel(rs_e, dst_m, reg_write_m, mem_to_reg_m, dst_w, reg_write_w);
    fwd_b_e = fwd_sel(rt_e, dst_m, reg_write_m, mem_to_reg_m, dst_w, reg_write_w);
  end

  // Load-use detection between the load in E and the consumer in D.
  always_comb begin
    lu_raw_s = 1'b0;
    if (mem_to_reg_e && reg_write_e && (dst_e != REG_ZERO) &&
        ((dst_e == rs_d) || (dst_e == rt_d))) begin
      lu_raw_s = 1'b1;
    end else begin
      lu_raw_s = 1'b0;
    end
  end

  // Multi-cycle countdown: load on entry, hold E while cnt > 1, release when cnt reaches 1.
  always_comb begin
    mc_raw_s = 1'b0;
    cnt_d    = cnt_q;
    if (cnt_q == CNT_ZERO) begin
      if (mc_op_e && MC_EN) begin
        mc_raw_s = 1'b1;
        cnt_d    = CNT_LOAD;
      end else begin
        cnt_d    = CNT_ZERO;
      end
    end else if (cnt_q == CNT_ONE) begin
      mc_raw_s = 1'b0;
      cnt_d    = CNT_ZERO;
    end else begin
      mc_raw_s = 1'b1;
      cnt_d    = cnt_q - CNT_ONE;
    end
  end

  // While reset is held every stall/flush request is suppressed, even if inputs still ask.
  always_comb begin
    lu_s       = lu_raw_s & resetn;
    mc_stall_s = mc_raw_s & resetn;
    redir_s    = redirect_e & resetn;
  end

  // Stall/flush arbitration: redirect beats both stalls, a multi-cycle hold beats load-use.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (redir_s) begin
      flush_d = 1'b1;
      stall_e = mc_stall_s;
      flush_m = mc_stall_s;
    end else if (mc_stall_s) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (lu_s) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      stall_f = 1'b0;
    end
  end

  // Busy flag reflects a countdown in flight, i.e. the op is past its first E cycle.
  always_comb begin
    mc_busy = (cnt_q != CNT_ZERO);
  end

  // Saturating performance counters; they stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && (stall_cnt_q != PERF_MAX)) begin
      stall_cnt_d = stall_cnt_q + PERF_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if ((flush_d || flush_e || flush_m) && (flush_cnt_q != PERF_MAX)) begin
      flush_cnt_d = flush_cnt_q + PERF_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State registers: countdown and counters clear asynchronously on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= CNT_ZERO;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Counter values are presented straight from their registers.
  always_comb begin
    stall_cycles = stall_cnt_q;
    flush_events = flush_cnt_q;
  end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Self-checking bench for hazard_ctrl_mc: directed scenarios plus randomized traffic
// checked against a residency-based reference model of the hazard rules.
module tb_hazard_ctrl_mc;
  localparam int REG_W   = 5;
  localparam int MC_LAT  = 4;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic resetn;
  logic [REG_W-1:0] rs_d, rt_d, rs_e, rt_e, dst_e, dst_m, dst_w;
  logic reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m, mc_op_e, redirect_e;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: cycles the current multi-cycle op has spent in E (0 = none).
  int m_age, m_next_age, m_stall_cnt, m_flush_cnt;
  logic [1:0] e_fwd_a, e_fwd_b;
  logic e_stall_f, e_stall_d, e_stall_e, e_flush_d, e_flush_e, e_flush_m, e_busy;

  hazard_ctrl_mc #(.REG_W(REG_W), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .dst_e(dst_e), .dst_m(dst_m), .dst_w(dst_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
    .mc_op_e(mc_op_e), .redirect_e(redirect_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .mc_busy(mc_busy), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] fwd_ref(input logic [REG_W-1:0] src);
    if (reg_write_m && !mem_to_reg_m && dst_m != 0 && dst_m == src) return 2'b10;
    if (reg_write_w && dst_w != 0 && dst_w == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0; dst_e = 0; dst_m = 0; dst_w = 0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
    mem_to_reg_e = 0; mem_to_reg_m = 0; mc_op_e = 0; redirect_e = 0;
  endtask

  task automatic model_reset();
    m_age = 0; m_stall_cnt = 0; m_flush_cnt = 0;
  endtask

  // Expected outputs for the current cycle, from the model state and the driven inputs.
  task automatic compute_expected();
    int cur;
    bit lu, mcs, rd;
    if (m_age == 0) cur = (mc_op_e && MC_LAT > 1) ? 1 : 0;
    else cur = m_age;
    mcs = (cur != 0) && (cur < MC_LAT);
    lu  = mem_to_reg_e && reg_write_e && dst_e != 0 && (dst_e == rs_d || dst_e == rt_d);
    rd  = redirect_e;
    if (!resetn) begin mcs = 0; lu = 0; rd = 0; end
    m_next_age = (cur == 0 || cur >= MC_LAT) ? 0 : cur + 1;
    e_fwd_a   = fwd_ref(rs_e);
    e_fwd_b   = fwd_ref(rt_e);
    e_stall_f = (mcs || lu) && !rd;
    e_stall_d = (mcs || lu) && !rd;
    e_stall_e = mcs;
    e_flush_m = mcs;
    e_flush_d = rd;
    e_flush_e = lu && !mcs && !rd;
    e_busy    = (m_age != 0);
  endtask

  task automatic settle();
    @(negedge clk);
    compute_expected();
  endtask

  // Commit this cycle into the model and move to just after the next rising edge.
  task automatic advance();
    if (resetn) begin
      m_age = m_next_age;
      if (e_stall_f && m_stall_cnt < CNT_MAX) m_stall_cnt++;
      if ((e_flush_d || e_flush_e || e_flush_m) && m_flush_cnt < CNT_MAX) m_flush_cnt++;
    end else begin
      model_reset();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 0; clear_inputs();
    mc_op_e = 1; mem_to_reg_e = 1; reg_write_e = 1; dst_e = 3; rs_d = 3;
    settle();
    n_checks++;
    if ({stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000000", {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy});
    end
    n_checks++;
    if (stall_cycles !== 0 || flush_events !== 0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, flush_events);
    end
    advance();
    clear_inputs(); resetn = 1;
    settle();
    n_checks++;
    if ({fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy} !== 11'b0) begin
      n_fail++; $display("FAIL reset_release: got %b expected all zero", {fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy});
    end
    advance();
  endtask

  task automatic test_forwarding();
    logic [1:0] exp_a [4];
    logic [1:0] exp_b [4];
    exp_a[0] = 2'b10; exp_b[0] = 2'b10;
    exp_a[1] = 2'b00; exp_b[1] = 2'b00;
    exp_a[2] = 2'b10; exp_b[2] = 2'b00;
    exp_a[3] = 2'b01; exp_b[3] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      case (i)
        0: begin reg_write_m = 1; dst_m = 5; rs_e = 5; rt_e = 5; end
        1: begin reg_write_m = 1; dst_m = 0; rs_e = 0; rt_e = 0; reg_write_w = 1; dst_w = 0; end
        2: begin reg_write_m = 1; reg_write_w = 1; dst_m = 7; dst_w = 7; rs_e = 7; rt_e = 2; end
        default: begin reg_write_m = 1; reg_write_w = 1; mem_to_reg_m = 1; dst_m = 7; dst_w = 7; rs_e = 7; rt_e = 2; end
      endcase
      settle();
      n_checks++;
      if (fwd_a_e !== exp_a[i] || fwd_b_e !== exp_b[i]) begin
        n_fail++; $display("FAIL fwd_case%0d: got %b/%b expected %b/%b", i, fwd_a_e, fwd_b_e, exp_a[i], exp_b[i]);
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    int s0;
    s0 = m_stall_cnt;
    clear_inputs(); mem_to_reg_e = 1; reg_write_e = 1; dst_e = 3; rt_d = 3;
    settle();
    n_checks++;
    if ({stall_f, stall_d, flush_e, stall_e} !== 4'b1110) begin
      n_fail++; $display("FAIL lu_stall: got %b expected 1110", {stall_f, stall_d, flush_e, stall_e});
    end
    advance();
    // Bubble now in E, load in M; the consumer is still in D.
    clear_inputs(); mem_to_reg_m = 1; reg_write_m = 1; dst_m = 3; rt_d = 3;
    settle();
    n_checks++;
    if ({stall_f, stall_d, flush_e} !== 3'b000 || stall_cycles !== CNT_W'(s0 + 1)) begin
      n_fail++; $display("FAIL lu_release: got %b cnt %0d expected 000 cnt %0d", {stall_f, stall_d, flush_e}, stall_cycles, s0 + 1);
    end
    advance();
    // Consumer in E, load data in W.
    clear_inputs(); reg_write_w = 1; dst_w = 3; rt_e = 3;
    settle();
    n_checks++;
    if (fwd_b_e !== 2'b01) begin
      n_fail++; $display("FAIL lu_fwd_w: got %b expected 01", fwd_b_e);
    end
    advance();
    // A load targeting register 0 is never a hazard.
    clear_inputs(); mem_to_reg_e = 1; reg_write_e = 1; dst_e = 0; rs_d = 0;
    settle();
    n_checks++;
    if (stall_f !== 1'b0 || flush_e !== 1'b0) begin
      n_fail++; $display("FAIL lu_r0: got %b%b expected 00", stall_f, flush_e);
    end
    advance();
  endtask

  task automatic test_multicycle();
    int s0;
    s0 = m_stall_cnt;
    clear_inputs(); mc_op_e = 1;
    for (int i = 0; i < MC_LAT; i++) begin
      settle();
      n_checks++;
      if ({stall_f, stall_d, stall_e, flush_m} !== {4{i < MC_LAT - 1}} || mc_busy !== (i >= 1)) begin
        n_fail++; $display("FAIL mc_cycle%0d: stalls %b busy %b expected %b busy %b", i,
                           {stall_f, stall_d, stall_e, flush_m}, mc_busy, {4{i < MC_LAT - 1}}, (i >= 1));
      end
      advance();
    end
    mc_op_e = 0;
    settle();
    n_checks++;
    if (mc_busy !== 1'b0 || stall_f !== 1'b0 || stall_cycles !== CNT_W'(s0 + MC_LAT - 1)) begin
      n_fail++; $display("FAIL mc_done: busy %b stall %b cnt %0d expected 0 0 %0d", mc_busy, stall_f, stall_cycles, s0 + MC_LAT - 1);
    end
    advance();
  endtask

  task automatic test_priority();
    int f0;
    clear_inputs(); mc_op_e = 1; mem_to_reg_e = 1; reg_write_e = 1; dst_e = 4; rs_d = 4;
    settle();
    n_checks++;
    if (stall_e !== 1'b1 || flush_e !== 1'b0 || stall_f !== 1'b1) begin
      n_fail++; $display("FAIL mc_over_lu: stall_e %b flush_e %b stall_f %b expected 1 0 1", stall_e, flush_e, stall_f);
    end
    advance();
    for (int i = 1; i < MC_LAT; i++) begin
      settle();
      n_checks++;
      if (stall_e !== e_stall_e || flush_e !== e_flush_e) begin
        n_fail++; $display("FAIL mc_lu_cycle%0d: %b%b expected %b%b", i, stall_e, flush_e, e_stall_e, e_flush_e);
      end
      advance();
    end
    clear_inputs(); mem_to_reg_e = 1; reg_write_e = 1; dst_e = 6; rt_d = 6; redirect_e = 1;
    f0 = m_flush_cnt;
    settle();
    n_checks++;
    if ({flush_d, stall_d, stall_f, flush_e} !== 4'b1000) begin
      n_fail++; $display("FAIL redirect_lu: got %b expected 1000", {flush_d, stall_d, stall_f, flush_e});
    end
    advance();
    clear_inputs();
    settle();
    n_checks++;
    if (flush_events !== CNT_W'(f0 + 1)) begin
      n_fail++; $display("FAIL redirect_count: got %0d expected %0d", flush_events, f0 + 1);
    end
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rs_d = REG_W'($urandom_range(0, 3)); rt_d = REG_W'($urandom_range(0, 3));
      rs_e = REG_W'($urandom_range(0, 3)); rt_e = REG_W'($urandom_range(0, 3));
      dst_e = REG_W'($urandom_range(0, 3)); dst_m = REG_W'($urandom_range(0, 3));
      dst_w = REG_W'($urandom_range(0, 3));
      reg_write_e = 1'($urandom); reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
      mem_to_reg_e = 1'($urandom); mem_to_reg_m = 1'($urandom);
      mc_op_e = (m_age != 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
      redirect_e = (!mc_op_e && m_age == 0) ? ($urandom_range(0, 5) == 0) : 1'b0;
      settle();
      n_checks++;
      if (fwd_a_e !== e_fwd_a || fwd_b_e !== e_fwd_b) begin
        n_fail++; $display("FAIL rnd_fwd c%0d: got %b/%b expected %b/%b", c, fwd_a_e, fwd_b_e, e_fwd_a, e_fwd_b);
      end
      n_checks++;
      if ({stall_f, stall_d, stall_e} !== {e_stall_f, e_stall_d, e_stall_e}) begin
        n_fail++; $display("FAIL rnd_stall c%0d: got %b expected %b", c, {stall_f, stall_d, stall_e}, {e_stall_f, e_stall_d, e_stall_e});
      end
      n_checks++;
      if ({flush_d, flush_e, flush_m} !== {e_flush_d, e_flush_e, e_flush_m}) begin
        n_fail++; $display("FAIL rnd_flush c%0d: got %b expected %b", c, {flush_d, flush_e, flush_m}, {e_flush_d, e_flush_e, e_flush_m});
      end
      n_checks++;
      if (mc_busy !== e_busy) begin
        n_fail++; $display("FAIL rnd_busy c%0d: got %b expected %b", c, mc_busy, e_busy);
      end
      n_checks++;
      if (stall_cycles !== CNT_W'(m_stall_cnt) || flush_events !== CNT_W'(m_flush_cnt)) begin
        n_fail++; $display("FAIL rnd_cnt c%0d: got %0d/%0d expected %0d/%0d", c, stall_cycles, flush_events, m_stall_cnt, m_flush_cnt);
      end
      advance();
    end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < CNT_MAX + 8; c++) begin
      clear_inputs(); mem_to_reg_e = 1; reg_write_e = 1; dst_e = 2; rs_d = 2;
      settle();
      n_checks++;
      if (stall_cycles !== CNT_W'(m_stall_cnt) || flush_events !== CNT_W'(m_flush_cnt)) begin
        n_fail++; $display("FAIL sat_track c%0d: got %0d/%0d expected %0d/%0d", c, stall_cycles, flush_events, m_stall_cnt, m_flush_cnt);
      end
      advance();
    end
    clear_inputs();
    settle();
    n_checks++;
    if (stall_cycles !== CNT_W'(CNT_MAX) || flush_events !== CNT_W'(CNT_MAX)) begin
      n_fail++; $display("FAIL sat_final: got %0d/%0d expected %0d/%0d", stall_cycles, flush_events, CNT_MAX, CNT_MAX);
    end
    advance();
  endtask

  task automatic test_reset_mid_countdown();
    clear_inputs();
    for (int i = 0; i < MC_LAT && m_age != 0; i++) begin
      settle(); advance();
    end
    mc_op_e = 1;
    settle(); advance();
    settle(); advance();
    settle();
    n_checks++;
    if (mc_busy !== 1'b1 || stall_f !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: busy %b stall %b expected 1 1", mc_busy, stall_f);
    end
    #1 resetn = 0;
    #1;
    n_checks++;
    if ({mc_busy, stall_f, stall_d, stall_e, flush_m} !== 5'b0) begin
      n_fail++; $display("FAIL mid_async: got %b expected 00000", {mc_busy, stall_f, stall_d, stall_e, flush_m});
    end
    n_checks++;
    if (stall_cycles !== 0 || flush_events !== 0) begin
      n_fail++; $display("FAIL mid_counters: got %0d/%0d expected 0/0", stall_cycles, flush_events);
    end
    model_reset();
    @(posedge clk); #1;
    clear_inputs(); resetn = 1;
    settle();
    n_checks++;
    if ({mc_busy, stall_f, stall_e} !== 3'b0 || stall_cycles !== 0 || flush_events !== 0) begin
      n_fail++; $display("FAIL mid_after: got %b %0d/%0d expected 000 0/0", {mc_busy, stall_f, stall_e}, stall_cycles, flush_events);
    end
    advance();
  endtask

  initial begin
    resetn = 0;
    clear_inputs();
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_multicycle();
    test_priority();
    test_random();
    test_saturation();
    test_reset_mid_countdown();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
